p4_ingress_rr_arbiter: RTL and testbench
========================================

Name: p4_ingress_rr_arbiter

Overview:
- Multi-channel ingress front-end for the Vitis Net P4 engine wrapper.
- Merges NUM_CH independent AXI4-Stream packet sources, each carrying its own user metadata, into the engine's single s_axis/user_metadata_in pair.
- Arbitration is packet-granular round-robin; the winning channel index is encoded into TID.
- Successor to the single-port engine interface: parametrised channel count, data width and metadata width.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- TDATA_NUM_BYTES, 4, bytes per beat on every channel and on the output.
- TID_WIDTH, 11, output TID width; must be >= CH_W.
- USER_META_DATA_WIDTH, 12, metadata bits per channel.
- CH_W, $clog2(NUM_CH), derived localparam; not overridable.

Ports:
- s_axis_aclk  in  1  sole clock
- s_axis_aresetn  in  1  async active-low reset
- s_axis_tdata  in  NUM_CH*TDATA_NUM_BYTES*8  per-channel data, channel c at slice c
- s_axis_tkeep  in  NUM_CH*TDATA_NUM_BYTES  per-channel keep
- s_axis_tvalid  in  NUM_CH  per-channel valid
- s_axis_tlast  in  NUM_CH  per-channel last
- s_axis_tready  out  NUM_CH  per-channel ready
- s_user_metadata  in  NUM_CH*USER_META_DATA_WIDTH  per-channel metadata, qualified by tvalid&tlast of that channel
- m_axis_tdata  out  TDATA_NUM_BYTES*8  merged data to engine
- m_axis_tkeep  out  TDATA_NUM_BYTES  merged keep
- m_axis_tvalid  out  1  merged valid
- m_axis_tlast  out  1  merged last
- m_axis_tid  out  TID_WIDTH  zero-extended granted channel index
- m_axis_tready  in  1  engine ready
- user_metadata_in  out  USER_META_DATA_WIDTH  metadata to engine
- user_metadata_in_valid  out  1  high only on output beats with tlast=1 and tvalid=1

Behaviour:
- Reset (async assert, sync deassert by the upstream reset bridge) clears state and grant:
  - state=IDLE, grant=0, last_grant=NUM_CH-1.
  - All outputs 0: m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, user_metadata_in, user_metadata_in_valid, s_axis_tready.
- FSM: IDLE -> XFER -> IDLE.
  - IDLE: all s_axis_tready=0. If any tvalid is set, grant = first requesting channel searching upward from last_grant+1 mod NUM_CH; move to XFER next cycle. If no tvalid is set, stay in IDLE.
  - XFER: only s_axis_tready[grant] may be 1, and it equals the skid buffer's in_ready. Every accepted beat is pushed to the output stage with tid=grant. If the beat carries tlast, s_user_metadata[grant] is pushed alongside it.
  - Accepted tlast beat: last_grant<=grant, state<=IDLE. This costs exactly one bubble cycle per packet.
- Output stage: 2-entry skid buffer.
  - Input-to-output latency is 1 cycle when m_axis_tready=1.
  - Sustained throughput is 1 beat/cycle within a packet.
  - No combinational path from m_axis_tready to s_axis_tready.
- AXIS rules: an asserted m_axis_tvalid never drops, and payload stays stable, until m_axis_tready.
- Fairness: with all channels continuously requesting, grants cycle 0,1,...,NUM_CH-1,0,...
- A single requester is re-granted after one IDLE cycle.
- Channels not granted are never readied; their beats wait upstream and none are dropped.
- Simultaneous requests: resolved by rotation only; index has no priority beyond rotation.
- tkeep is passed through unmodified, including all-zero keep.
- Metadata is sampled only on a granted tlast beat. It is ignored on other beats and on other channels.
- Reset mid-packet: the partially sent packet is abandoned without tlast. After reset, the next beat on any channel is treated as a packet start.

Optional Feature:
- Macro: P4_INGRESS_ARB_STATS_EN.
- Defined:
  - Adds output stat_pkt_cnt, width NUM_CH*32, with one counter per channel.
  - Adds input stat_clr, width 1.
  - A counter increments on each accepted tlast beat of its channel and saturates at 32'hFFFF_FFFF.
  - stat_clr zeroes all counters synchronously. If stat_clr coincides with an increment, the result is 0.
  - Async reset zeroes all counters.
- Not defined: ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package p4_ingress_arb_pkg holds:
  - the FSM state enum {IDLE, XFER};
  - STAT_W=32;
  - the function rr_next(req, last) returning the next grant index.
- Sub-module: axis_meta_skid_buffer.
  - Parametrised by payload width (data+keep+last+tid+meta+meta_valid).
  - Handles valid/ready, the 2-entry buffer and reset.

Test Plan:
- Single channel 2, 3-beat packet, meta=12'hABC, tready=1: 3 output beats, tid=2, user_metadata_in_valid=1 only on beat 3 with value 12'hABC; first output 1 cycle after first accept.
- All 4 channels continuously sending 1-beat packets: tid sequence 0,1,2,3,0,1 with exactly one idle cycle between packets.
- m_axis_tready toggling 1,0,0,1 during an 8-beat packet: all 8 beats delivered in order with none lost or duplicated, and payload stable while stalled.
- Channel 1 valid mid-packet of channel 0: s_axis_tready[1] stays 0 until channel 0's tlast is accepted; channel 1 is granted next.
- Reset asserted at beat 2 of 5: all outputs 0 within the same cycle; after release, a fresh channel 3 packet is forwarded correctly.
- STATS_EN with 5 packets on ch0 and 2 on ch3: stat_pkt_cnt reads {0,0,5}/2 as ch0=5, ch3=2, others 0; stat_clr coincident with a ch0 tlast gives 0.

Source files
------------

// File: rtl/p4_ingress_rr_arbiter_pkg.sv
// Shared types and helpers for the P4 ingress round-robin arbiter.
package p4_ingress_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    localparam int unsigned STAT_W   = 32;
    localparam int unsigned MAX_CH   = 16;
    localparam int unsigned MAX_CH_W = 4;

    // First requester strictly after 'last', wrapping modulo num_ch; holds 'last' when idle.
    function automatic logic [MAX_CH_W-1:0] rr_next(input logic [MAX_CH-1:0]   req,
                                                    input logic [MAX_CH_W-1:0] last,
                                                    input int unsigned         num_ch);
        logic [MAX_CH_W-1:0] pick;
        logic                found;
        int unsigned         idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_CH; i++) begin
            idx = (32'(last) + i) % num_ch;
            if (i <= num_ch && !found && req[MAX_CH_W'(idx)]) begin
                pick  = MAX_CH_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/p4_ingress_rr_arbiter_if.sv
// Channel-side and engine-side AXI4-Stream bundle of the ingress arbiter.
interface p4_ingress_rr_arbiter_if #(
    parameter int unsigned NUM_CH               = 4,
    parameter int unsigned TDATA_NUM_BYTES      = 4,
    parameter int unsigned TID_WIDTH            = 11,
    parameter int unsigned USER_META_DATA_WIDTH = 12
);
    logic [NUM_CH*TDATA_NUM_BYTES*8-1:0]    s_axis_tdata;
    logic [NUM_CH*TDATA_NUM_BYTES-1:0]      s_axis_tkeep;
    logic [NUM_CH-1:0]                      s_axis_tvalid;
    logic [NUM_CH-1:0]                      s_axis_tlast;
    logic [NUM_CH-1:0]                      s_axis_tready;
    logic [NUM_CH*USER_META_DATA_WIDTH-1:0] s_user_metadata;
    logic [TDATA_NUM_BYTES*8-1:0]           m_axis_tdata;
    logic [TDATA_NUM_BYTES-1:0]             m_axis_tkeep;
    logic                                   m_axis_tvalid;
    logic                                   m_axis_tlast;
    logic [TID_WIDTH-1:0]                   m_axis_tid;
    logic                                   m_axis_tready;
    logic [USER_META_DATA_WIDTH-1:0]        user_metadata_in;
    logic                                   user_metadata_in_valid;

    // Arbiter view
    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_user_metadata,
        input  m_axis_tready,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid,
        output user_metadata_in, user_metadata_in_valid
    );

    // Sources and engine view
    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_user_metadata,
        output m_axis_tready,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid,
        input  user_metadata_in, user_metadata_in_valid
    );
endinterface

// File: rtl/p4_ingress_rr_arbiter_skid.sv
// Two-entry skid buffer: registered output stage, in_ready depends only on local state.
module axis_meta_skid_buffer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         skid_valid_q;
    logic [W-1:0] skid_data_q;
    logic         out_valid_q;
    logic [W-1:0] out_data_q;

    assign in_ready  = !skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Incoming beats go straight to the output register unless it is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else if (!skid_valid_q) begin
            if (in_valid) begin
                if (!out_valid_q || out_ready) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= in_data;
                end else begin
                    skid_valid_q <= 1'b1;
                    skid_data_q  <= in_data;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end else if (out_ready) begin
            out_data_q   <= skid_data_q;
            skid_valid_q <= 1'b0;
        end
    end
endmodule

// File: rtl/p4_ingress_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_CH AXIS+metadata sources onto one engine port.
// Optional per-channel packet counters with `define P4_INGRESS_ARB_STATS_EN.
module p4_ingress_rr_arbiter
    import p4_ingress_arb_pkg::*;
#(
    parameter int unsigned NUM_CH               = 4,
    parameter int unsigned TDATA_NUM_BYTES      = 4,
    parameter int unsigned TID_WIDTH            = 11,
    parameter int unsigned USER_META_DATA_WIDTH = 12
) (
    input  logic                       s_axis_aclk,
    input  logic                       s_axis_aresetn,
`ifdef P4_INGRESS_ARB_STATS_EN
    input  logic                       stat_clr,
    output logic [NUM_CH*STAT_W-1:0]   stat_pkt_cnt,
`endif
    p4_ingress_rr_arbiter_if.slave     axis
);
    localparam int unsigned CH_W = $clog2(NUM_CH);
    localparam int unsigned DW   = TDATA_NUM_BYTES * 8;
    localparam int unsigned KW   = TDATA_NUM_BYTES;
    localparam int unsigned MW   = USER_META_DATA_WIDTH;
    localparam int unsigned PW   = DW + KW + 1 + TID_WIDTH + MW + 1;

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;

    logic [DW-1:0]     sel_data;
    logic [KW-1:0]     sel_keep;
    logic [MW-1:0]     sel_meta;
    logic              sel_valid;
    logic              sel_last;
    logic              push_valid;
    logic              in_ready;
    logic              beat_acc;
    logic [NUM_CH-1:0] tready;
    logic [PW-1:0]     in_payload;
    logic [PW-1:0]     out_payload;

    // Mux the granted channel's beat.
    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_meta  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (grant_q == CH_W'(c)) begin
                sel_data  = axis.s_axis_tdata[c*DW +: DW];
                sel_keep  = axis.s_axis_tkeep[c*KW +: KW];
                sel_meta  = axis.s_user_metadata[c*MW +: MW];
                sel_valid = axis.s_axis_tvalid[c];
                sel_last  = axis.s_axis_tlast[c];
            end
        end
    end

    assign push_valid = (state_q == XFER) && sel_valid;
    assign beat_acc   = push_valid && in_ready;

    // Only the granted channel is readied, and only while the skid has room.
    always_comb begin
        tready = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            tready[c] = (state_q == XFER) && in_ready && (grant_q == CH_W'(c));
        end
    end
    assign axis.s_axis_tready = tready;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (|axis.s_axis_tvalid) begin
                    grant_d = CH_W'(rr_next(MAX_CH'(axis.s_axis_tvalid),
                                            MAX_CH_W'(last_grant_q), NUM_CH));
                    state_d = XFER;
                end
            end
            XFER: begin
                if (beat_acc && sel_last) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign in_payload = {sel_data, sel_keep, sel_last, TID_WIDTH'(grant_q),
                         sel_last ? sel_meta : MW'(0), sel_last};

    axis_meta_skid_buffer #(.W(PW)) u_skid (
        .clk       (s_axis_aclk),
        .rst_n     (s_axis_aresetn),
        .in_valid  (push_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (axis.m_axis_tvalid),
        .out_ready (axis.m_axis_tready),
        .out_data  (out_payload)
    );

    assign {axis.m_axis_tdata, axis.m_axis_tkeep, axis.m_axis_tlast, axis.m_axis_tid,
            axis.user_metadata_in, axis.user_metadata_in_valid} = out_payload;

`ifdef P4_INGRESS_ARB_STATS_EN
    logic [NUM_CH-1:0][STAT_W-1:0] cnt_q;

    // Saturating per-channel packet counters; clear beats a coincident increment.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            cnt_q <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (stat_clr) begin
                    cnt_q[c] <= '0;
                end else if (beat_acc && sel_last && grant_q == CH_W'(c) && cnt_q[c] != '1) begin
                    cnt_q[c] <= cnt_q[c] + STAT_W'(1);
                end
            end
        end
    end

    assign stat_pkt_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_p4_ingress_rr_arbiter.sv
// Directed bench for p4_ingress_rr_arbiter (4 channels, 32-bit data, 12-bit metadata).
module tb_p4_ingress_rr_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    p4_ingress_rr_arbiter_if #(.NUM_CH(4), .TDATA_NUM_BYTES(4), .TID_WIDTH(11),
                               .USER_META_DATA_WIDTH(12)) bus ();

`ifdef P4_INGRESS_ARB_STATS_EN
    logic         stat_clr;
    logic [127:0] stat_pkt_cnt;
`endif

    p4_ingress_rr_arbiter #(.NUM_CH(4), .TDATA_NUM_BYTES(4), .TID_WIDTH(11),
                            .USER_META_DATA_WIDTH(12)) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
`ifdef P4_INGRESS_ARB_STATS_EN
        .stat_clr       (stat_clr),
        .stat_pkt_cnt   (stat_pkt_cnt),
`endif
        .axis           (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [10:0] tid;
        logic [11:0] meta;
        logic        mv;
        int          cyc;
    } beat_t;

    beat_t out_q[$];
    int    acc_q[$];

    // Output beats and input accepts, sampled on the falling edge before the handshake edge.
    always @(negedge clk) begin : mon
        beat_t b;
        if (rst_n && bus.m_axis_tvalid && bus.m_axis_tready) begin
            b.data = bus.m_axis_tdata;  b.keep = bus.m_axis_tkeep;
            b.last = bus.m_axis_tlast;  b.tid  = bus.m_axis_tid;
            b.meta = bus.user_metadata_in; b.mv = bus.user_metadata_in_valid;
            b.cyc  = cyc;
            out_q.push_back(b);
        end
        if (rst_n && |(bus.s_axis_tvalid & bus.s_axis_tready)) acc_q.push_back(cyc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.s_axis_tdata    = '0;
        bus.s_axis_tkeep    = '0;
        bus.s_axis_tvalid   = '0;
        bus.s_axis_tlast    = '0;
        bus.s_user_metadata = '0;
        bus.m_axis_tready   = 1'b1;
`ifdef P4_INGRESS_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        out_q.delete();
        acc_q.delete();
    endtask

    // Sends the first nsend beats of an nbeats packet; data = base+beat, keep = data[3:0].
    task automatic drive_pkt(input int ch, input int nbeats, input int nsend,
                             input logic [31:0] base, input logic [11:0] meta);
        int          n;
        logic [31:0] d;
        for (int b = 0; b < nsend; b++) begin
            d = base + 32'(b);
            bus.s_axis_tdata[ch*32 +: 32]    = d;
            bus.s_axis_tkeep[ch*4 +: 4]      = d[3:0];
            bus.s_axis_tlast[ch]             = (b == nbeats - 1);
            bus.s_user_metadata[ch*12 +: 12] = (b == nbeats - 1) ? meta : 12'h5A5;
            bus.s_axis_tvalid[ch]            = 1'b1;
            n = 0;
            @(negedge clk);
            while (!bus.s_axis_tready[ch] && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!bus.s_axis_tready[ch]) begin
                n_checks++; n_fail++;
                $display("FAIL accept_timeout ch%0d beat %0d: tready=0, required 1", ch, b);
            end
            step();
        end
        bus.s_axis_tvalid[ch] = 1'b0;
        bus.s_axis_tlast[ch]  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.s_axis_tvalid = 4'hF;
        repeat (3) step();
        n_checks++; if (bus.m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid got %b want 0", bus.m_axis_tvalid); end
        n_checks++; if (bus.m_axis_tdata !== 32'h0) begin n_fail++; $display("FAIL rst_tdata got %h want 0", bus.m_axis_tdata); end
        n_checks++; if (bus.m_axis_tkeep !== 4'h0) begin n_fail++; $display("FAIL rst_tkeep got %h want 0", bus.m_axis_tkeep); end
        n_checks++; if (bus.m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast got %b want 0", bus.m_axis_tlast); end
        n_checks++; if (bus.m_axis_tid !== 11'h0) begin n_fail++; $display("FAIL rst_tid got %h want 0", bus.m_axis_tid); end
        n_checks++; if (bus.user_metadata_in !== 12'h0) begin n_fail++; $display("FAIL rst_meta got %h want 0", bus.user_metadata_in); end
        n_checks++; if (bus.user_metadata_in_valid !== 1'b0) begin n_fail++; $display("FAIL rst_meta_valid got %b want 0", bus.user_metadata_in_valid); end
        n_checks++; if (bus.s_axis_tready !== 4'h0) begin n_fail++; $display("FAIL rst_s_tready got %b want 0000", bus.s_axis_tready); end
        bus.s_axis_tvalid = '0;
    endtask

    task automatic test_single_pkt();
        logic [31:0] e;
        apply_reset();
        drive_pkt(2, 3, 3, 32'h0000_00A0, 12'hABC);
        repeat (4) step();
        n_checks++; if (out_q.size() !== 3) begin n_fail++; $display("FAIL single_count got %0d want 3", out_q.size()); end
        for (int i = 0; i < 3 && i < out_q.size(); i++) begin
            e = 32'h0000_00A0 + 32'(i);
            n_checks++;
            if ({out_q[i].data, out_q[i].keep, out_q[i].last, out_q[i].tid, out_q[i].mv} !==
                {e, e[3:0], (i == 2), 11'd2, (i == 2)}) begin
                n_fail++;
                $display("FAIL single_beat%0d got d=%h k=%h l=%b tid=%0d mv=%b want d=%h k=%h l=%b tid=2 mv=%b",
                         i, out_q[i].data, out_q[i].keep, out_q[i].last, out_q[i].tid, out_q[i].mv,
                         e, e[3:0], (i == 2), (i == 2));
            end
        end
        if (out_q.size() == 3) begin
            n_checks++; if (out_q[2].meta !== 12'hABC) begin n_fail++; $display("FAIL single_meta got %h want abc", out_q[2].meta); end
        end
        if (out_q.size() > 0 && acc_q.size() > 0) begin
            n_checks++;
            if (out_q[0].cyc - acc_q[0] !== 1) begin n_fail++; $display("FAIL single_latency got %0d want 1", out_q[0].cyc - acc_q[0]); end
        end
    endtask

    task automatic test_fairness();
        int exp_tid[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp_pkt[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        apply_reset();
        fork
            begin drive_pkt(0, 1, 1, 32'h0000_1000, 12'h100); drive_pkt(0, 1, 1, 32'h0000_1001, 12'h101); end
            begin drive_pkt(1, 1, 1, 32'h0000_1100, 12'h110); drive_pkt(1, 1, 1, 32'h0000_1101, 12'h111); end
            begin drive_pkt(2, 1, 1, 32'h0000_1200, 12'h120); drive_pkt(2, 1, 1, 32'h0000_1201, 12'h121); end
            begin drive_pkt(3, 1, 1, 32'h0000_1300, 12'h130); drive_pkt(3, 1, 1, 32'h0000_1301, 12'h131); end
        join
        repeat (4) step();
        n_checks++; if (out_q.size() !== 8) begin n_fail++; $display("FAIL rr_count got %0d want 8", out_q.size()); end
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i].tid !== 11'(exp_tid[i]) ||
                out_q[i].data !== 32'h0000_1000 + 32'(exp_tid[i] * 256 + exp_pkt[i])) begin
                n_fail++;
                $display("FAIL rr_beat%0d got tid=%0d d=%h want tid=%0d", i, out_q[i].tid, out_q[i].data, exp_tid[i]);
            end
            if (i > 0 && i < 6) begin
                n_checks++;
                if (out_q[i].cyc - out_q[i-1].cyc !== 2) begin
                    n_fail++; $display("FAIL rr_gap%0d got %0d cycles want 2", i, out_q[i].cyc - out_q[i-1].cyc);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic        prev_stall;
        logic [47:0] prev_pl;
        logic [47:0] cur_pl;
        apply_reset();
        prev_stall = 1'b0;
        prev_pl    = '0;
        fork
            drive_pkt(0, 8, 8, 32'h0000_2000, 12'h123);
            for (int i = 0; i < 40; i++) begin
                bus.m_axis_tready = pat[i % 4];
                @(negedge clk);
                cur_pl = {bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast, bus.m_axis_tid};
                if (prev_stall) begin
                    n_checks++;
                    if (bus.m_axis_tvalid !== 1'b1 || cur_pl !== prev_pl) begin
                        n_fail++;
                        $display("FAIL bp_stable cyc %0d got v=%b pl=%h want v=1 pl=%h", cyc, bus.m_axis_tvalid, cur_pl, prev_pl);
                    end
                end
                prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
                prev_pl    = cur_pl;
                step();
            end
        join
        bus.m_axis_tready = 1'b1;
        repeat (3) step();
        n_checks++; if (out_q.size() !== 8) begin n_fail++; $display("FAIL bp_count got %0d want 8", out_q.size()); end
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i].data !== 32'h0000_2000 + 32'(i) || out_q[i].last !== (i == 7) || out_q[i].tid !== 11'd0) begin
                n_fail++;
                $display("FAIL bp_beat%0d got d=%h l=%b tid=%0d want d=%h l=%b tid=0",
                         i, out_q[i].data, out_q[i].last, out_q[i].tid, 32'h0000_2000 + 32'(i), (i == 7));
            end
        end
    endtask

    task automatic test_hold_off();
        int   viol;
        logic seen;
        apply_reset();
        viol = 0;
        seen = 1'b0;
        fork
            drive_pkt(0, 4, 4, 32'h0000_3000, 12'h111);
            begin repeat (2) step(); drive_pkt(1, 2, 2, 32'h0000_3100, 12'h222); end
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (!seen && bus.s_axis_tready[1]) viol++;
                if (bus.s_axis_tvalid[0] && bus.s_axis_tready[0] && bus.s_axis_tlast[0]) seen = 1'b1;
            end
        join
        repeat (3) step();
        n_checks++; if (viol !== 0 || seen !== 1'b1) begin n_fail++; $display("FAIL hold_ready1 got %0d early readies (ch0 tlast seen=%b) want 0", viol, seen); end
        n_checks++; if (out_q.size() !== 6) begin n_fail++; $display("FAIL hold_count got %0d want 6", out_q.size()); end
        for (int i = 0; i < 6 && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i].tid !== ((i < 4) ? 11'd0 : 11'd1)) begin
                n_fail++; $display("FAIL hold_tid%0d got %0d want %0d", i, out_q[i].tid, (i < 4) ? 0 : 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive_pkt(0, 5, 2, 32'h0000_4000, 12'h444);
        n_checks++; if (bus.m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b want 1", bus.m_axis_tvalid); end
        bus.s_axis_tvalid[0] = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tid, bus.user_metadata_in_valid, bus.s_axis_tready} !== '0) begin
            n_fail++;
            $display("FAIL mid_rst_outputs got v=%b d=%h l=%b tid=%0d mv=%b rdy=%b want all 0", bus.m_axis_tvalid,
                     bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tid, bus.user_metadata_in_valid, bus.s_axis_tready);
        end
        idle_inputs();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        out_q.delete();
        acc_q.delete();
        drive_pkt(3, 3, 3, 32'h0000_4100, 12'hDEF);
        repeat (4) step();
        n_checks++; if (out_q.size() !== 3) begin n_fail++; $display("FAIL mid_count got %0d want 3", out_q.size()); end
        for (int i = 0; i < 3 && i < out_q.size(); i++) begin
            n_checks++;
            if (out_q[i].data !== 32'h0000_4100 + 32'(i) || out_q[i].tid !== 11'd3 ||
                out_q[i].last !== (i == 2) || out_q[i].mv !== (i == 2)) begin
                n_fail++;
                $display("FAIL mid_beat%0d got d=%h tid=%0d l=%b mv=%b want d=%h tid=3 l=%b",
                         i, out_q[i].data, out_q[i].tid, out_q[i].last, out_q[i].mv, 32'h0000_4100 + 32'(i), (i == 2));
            end
        end
        if (out_q.size() == 3) begin
            n_checks++; if (out_q[2].meta !== 12'hDEF) begin n_fail++; $display("FAIL mid_meta got %h want def", out_q[2].meta); end
        end
    endtask

`ifdef P4_INGRESS_ARB_STATS_EN
    task automatic test_stats();
        logic [31:0] exp_cnt[4] = '{32'd5, 32'd0, 32'd0, 32'd2};
        logic        hit;
        apply_reset();
        fork
            for (int k = 0; k < 5; k++) drive_pkt(0, 2, 2, 32'h0000_5000 + 32'(k * 16), 12'h500);
            for (int k = 0; k < 2; k++) drive_pkt(3, 1, 1, 32'h0000_5300 + 32'(k), 12'h530);
        join
        repeat (3) step();
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (stat_pkt_cnt[c*32 +: 32] !== exp_cnt[c]) begin
                n_fail++; $display("FAIL stat_cnt%0d got %0d want %0d", c, stat_pkt_cnt[c*32 +: 32], exp_cnt[c]);
            end
        end
        hit = 1'b0;
        fork
            drive_pkt(0, 1, 1, 32'h0000_5500, 12'h550);
            for (int i = 0; i < 50 && !hit; i++) begin
                @(negedge clk);
                if (bus.s_axis_tvalid[0] && bus.s_axis_tready[0] && bus.s_axis_tlast[0]) begin
                    stat_clr = 1'b1;
                    hit      = 1'b1;
                    step();
                    stat_clr = 1'b0;
                end
            end
        join
        step();
        n_checks++; if (stat_pkt_cnt !== 128'h0) begin n_fail++; $display("FAIL stat_clr_coincident got %h want 0 (hit=%b)", stat_pkt_cnt, hit); end
        drive_pkt(3, 1, 1, 32'h0000_5600, 12'h560);
        repeat (2) step();
        n_checks++; if (stat_pkt_cnt[96 +: 32] !== 32'd1) begin n_fail++; $display("FAIL stat_after_clr got %0d want 1", stat_pkt_cnt[96 +: 32]); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single_pkt();
        test_fairness();
        test_backpressure();
        test_hold_off();
        test_reset_mid();
`ifdef P4_INGRESS_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
